// File: rtl/vec_pkg.sv
// Shared encodings for the vector issue sequencer: instruction match constants,
// funct7 op codes, micro-op/SEW encodings and FSM state values.
package vec_pkg;

   localparam logic [6:0] OPC_VEC = 7'h5B;
   localparam logic [2:0] F3_VEC  = 3'b010;

   localparam logic [4:0] F7_VADD = 5'b00000;
   localparam logic [4:0] F7_VSUB = 5'b00001;
   localparam logic [4:0] F7_VMUL = 5'b00010;
   localparam logic [4:0] F7_VLD  = 5'b00100;
   localparam logic [4:0] F7_VST  = 5'b00101;
   localparam logic [4:0] F7_S2V  = 5'b01000;
   localparam logic [4:0] F7_V2S  = 5'b01001;

   typedef logic [2:0] vop_t;
   localparam vop_t VOP_VADD = 3'd0;
   localparam vop_t VOP_VSUB = 3'd1;
   localparam vop_t VOP_VMUL = 3'd2;
   localparam vop_t VOP_VLD  = 3'd3;
   localparam vop_t VOP_VST  = 3'd4;
   localparam vop_t VOP_S2V  = 3'd5;
   localparam vop_t VOP_V2S  = 3'd6;

   localparam logic [1:0] SEW_8   = 2'b00;
   localparam logic [1:0] SEW_16  = 2'b01;
   localparam logic [1:0] SEW_32  = 2'b10;
   localparam logic [1:0] SEW_BAD = 2'b11;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_ISSUE = 1'b1;

   function automatic logic vop_is_mem(input vop_t v);
      return (v == VOP_VLD) || (v == VOP_VST);
   endfunction

   function automatic logic vop_writes_vreg(input vop_t v);
      return (v == VOP_VADD) || (v == VOP_VSUB) || (v == VOP_VMUL) ||
             (v == VOP_VLD) || (v == VOP_S2V);
   endfunction

endpackage

// File: rtl/vec_insn_decode.sv
// Combinational field decode and legality check for one vector instruction word.
// Register use: arithmetic reads vd/vs1/vs2; VLD, VST (store data) and S2V use vd; V2S reads vs2.
module vec_insn_decode
   import vec_pkg::*;
#(
   parameter int NVREG = 8,
   parameter int VR_W  = $clog2(NVREG)
) (
   input  logic [31:0]     insn,
   output logic            is_vec,
   output logic            legal,
   output logic [2:0]      vop,
   output logic [1:0]      sew,
   output logic [VR_W-1:0] vd,
   output logic [VR_W-1:0] vs1,
   output logic [VR_W-1:0] vs2
);

   logic [4:0] f_op, f_vd, f_vs1, f_vs2;
   logic       use_vd, use_vs1, use_vs2, op_ok, regs_ok;

   assign f_op  = insn[29:25];
   assign f_vd  = insn[11:7];
   assign f_vs1 = insn[19:15];
   assign f_vs2 = insn[24:20];

   assign is_vec = (insn[6:0] == OPC_VEC) && (insn[14:12] == F3_VEC);
   assign sew    = insn[31:30];
   assign vd     = f_vd[VR_W-1:0];
   assign vs1    = f_vs1[VR_W-1:0];
   assign vs2    = f_vs2[VR_W-1:0];

   always_comb begin
      vop     = VOP_VADD;
      use_vd  = 1'b0;
      use_vs1 = 1'b0;
      use_vs2 = 1'b0;
      op_ok   = 1'b1;
      case (f_op)
         F7_VADD: begin vop = VOP_VADD; use_vd = 1'b1; use_vs1 = 1'b1; use_vs2 = 1'b1; end
         F7_VSUB: begin vop = VOP_VSUB; use_vd = 1'b1; use_vs1 = 1'b1; use_vs2 = 1'b1; end
         F7_VMUL: begin vop = VOP_VMUL; use_vd = 1'b1; use_vs1 = 1'b1; use_vs2 = 1'b1; end
         F7_VLD:  begin vop = VOP_VLD;  use_vd = 1'b1; end
         F7_VST:  begin vop = VOP_VST;  use_vd = 1'b1; end
         F7_S2V:  begin vop = VOP_S2V;  use_vd = 1'b1; end
         F7_V2S:  begin vop = VOP_V2S;  use_vs2 = 1'b1; end
         default: op_ok = 1'b0;
      endcase
      regs_ok = !(use_vd  && (32'(f_vd)  >= NVREG)) &&
                !(use_vs1 && (32'(f_vs1) >= NVREG)) &&
                !(use_vs2 && (32'(f_vs2) >= NVREG));
      legal = is_vec && op_ok && (sew != SEW_BAD) && regs_ok;
   end

endmodule

// File: rtl/vec_issue_seq.sv
// Vector issue sequencer: accepts one instruction at a time and expands it into
// per-beat micro-ops with registered outputs and per-beat load/store addresses.
module vec_issue_seq
   import vec_pkg::*;
#(
   parameter  int VLEN   = 128,
   parameter  int LANE_W = 32,
   parameter  int NVREG  = 8,
   parameter  int XLEN   = 32,
   localparam int NBEATS = VLEN / LANE_W,
   localparam int BEAT_W = $clog2(NBEATS),
   localparam int VR_W   = $clog2(NVREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_insn,
   input  logic [XLEN-1:0]   in_rs1_val,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        out_vop,
   output logic [1:0]        out_sew,
   output logic [VR_W-1:0]   out_vd,
   output logic [VR_W-1:0]   out_vs1,
   output logic [VR_W-1:0]   out_vs2,
   output logic [BEAT_W-1:0] out_beat,
   output logic              out_last,
   output logic [XLEN-1:0]   out_addr,
   output logic [XLEN-1:0]   out_scalar,
   output logic              out_vreg_write,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_scalar_wb,
   output logic              illegal,
   output logic              busy
);

   localparam logic [XLEN-1:0]   ADDR_STEP = XLEN'(LANE_W / 8);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

   logic            dec_is_vec, dec_legal;
   logic [2:0]      dec_vop;
   logic [1:0]      dec_sew;
   logic [VR_W-1:0] dec_vd, dec_vs1, dec_vs2;

   vec_insn_decode #(.NVREG(NVREG), .VR_W(VR_W)) u_dec (
      .insn   (in_insn),
      .is_vec (dec_is_vec),
      .legal  (dec_legal),
      .vop    (dec_vop),
      .sew    (dec_sew),
      .vd     (dec_vd),
      .vs1    (dec_vs1),
      .vs2    (dec_vs2)
   );

   logic              state_q, state_d, rst_done_q, rst_done_d;
   logic [2:0]        vop_q, vop_d;
   logic [1:0]        sew_q, sew_d;
   logic [VR_W-1:0]   vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
   logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;
   logic [XLEN-1:0]   addr_q, addr_d, scalar_q, scalar_d;
   logic              last_q, last_d, vreg_write_q, vreg_write_d;
   logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic              scalar_wb_q, scalar_wb_d, illegal_q, illegal_d;
   logic              fire, accept, load;

   assign beat_inc = beat_q + BEAT_W'(1);

   always_comb begin
      fire     = (state_q == ST_ISSUE) && out_ready;
      in_ready = rst_done_q && !flush && ((state_q == ST_IDLE) || (fire && last_q));
      accept   = in_valid && in_ready;
      load     = accept && dec_is_vec && dec_legal;

      rst_done_d   = 1'b1;
      illegal_d    = accept && dec_is_vec && !dec_legal;
      state_d      = state_q;
      vop_d        = vop_q;
      sew_d        = sew_q;
      vd_d         = vd_q;
      vs1_d        = vs1_q;
      vs2_d        = vs2_q;
      beat_d       = beat_q;
      addr_d       = addr_q;
      scalar_d     = scalar_q;
      last_d       = last_q;
      vreg_write_d = vreg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      scalar_wb_d  = scalar_wb_q;

      // Outputs read as zero whenever no micro-op is being offered.
      if (flush || (fire && last_q)) begin
         state_d      = ST_IDLE;
         vop_d        = '0;
         sew_d        = '0;
         vd_d         = '0;
         vs1_d        = '0;
         vs2_d        = '0;
         beat_d       = '0;
         addr_d       = '0;
         scalar_d     = '0;
         last_d       = 1'b0;
         vreg_write_d = 1'b0;
         mem_read_d   = 1'b0;
         mem_write_d  = 1'b0;
         scalar_wb_d  = 1'b0;
      end

      if (load) begin
         state_d      = ST_ISSUE;
         vop_d        = dec_vop;
         sew_d        = dec_sew;
         vd_d         = dec_vd;
         vs1_d        = dec_vs1;
         vs2_d        = dec_vs2;
         beat_d       = '0;
         addr_d       = vop_is_mem(dec_vop) ? in_rs1_val : '0;
         scalar_d     = in_rs1_val;
         last_d       = (dec_vop == VOP_V2S);
         vreg_write_d = vop_writes_vreg(dec_vop);
         mem_read_d   = (dec_vop == VOP_VLD);
         mem_write_d  = (dec_vop == VOP_VST);
         scalar_wb_d  = (dec_vop == VOP_V2S);
      end else if (!flush && fire && !last_q) begin
         beat_d = beat_inc;
         addr_d = (mem_read_q || mem_write_q) ? addr_q + ADDR_STEP : addr_q;
         last_d = (beat_inc == LAST_BEAT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rst_done_q   <= 1'b0;
         vop_q        <= '0;
         sew_q        <= '0;
         vd_q         <= '0;
         vs1_q        <= '0;
         vs2_q        <= '0;
         beat_q       <= '0;
         addr_q       <= '0;
         scalar_q     <= '0;
         last_q       <= 1'b0;
         vreg_write_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         scalar_wb_q  <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rst_done_q   <= rst_done_d;
         vop_q        <= vop_d;
         sew_q        <= sew_d;
         vd_q         <= vd_d;
         vs1_q        <= vs1_d;
         vs2_q        <= vs2_d;
         beat_q       <= beat_d;
         addr_q       <= addr_d;
         scalar_q     <= scalar_d;
         last_q       <= last_d;
         vreg_write_q <= vreg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         scalar_wb_q  <= scalar_wb_d;
         illegal_q    <= illegal_d;
      end
   end

   assign out_valid      = (state_q == ST_ISSUE);
   assign busy           = (state_q != ST_IDLE);
   assign out_vop        = vop_q;
   assign out_sew        = sew_q;
   assign out_vd         = vd_q;
   assign out_vs1        = vs1_q;
   assign out_vs2        = vs2_q;
   assign out_beat       = beat_q;
   assign out_last       = last_q;
   assign out_addr       = addr_q;
   assign out_scalar     = scalar_q;
   assign out_vreg_write = vreg_write_q;
   assign out_mem_read   = mem_read_q;
   assign out_mem_write  = mem_write_q;
   assign out_scalar_wb  = scalar_wb_q;
   assign illegal        = illegal_q;

endmodule

// File: tb/tb_vec_issue_seq.sv
// Self-checking bench for vec_issue_seq: directed test-plan cases plus random
// instruction streams, checked every cycle against a beat-list reference model.
module tb_vec_issue_seq;

   localparam int NBEATS = 4;
   localparam int NVREG  = 8;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [31:0] in_insn = '0, in_rs1_val = '0;
   logic        in_ready, out_valid, out_last, out_vreg_write, out_mem_read;
   logic        out_mem_write, out_scalar_wb, illegal, busy;
   logic [2:0]  out_vop, out_vd, out_vs1, out_vs2;
   logic [1:0]  out_sew, out_beat;
   logic [31:0] out_addr, out_scalar;

   always #5 clk = ~clk;

   vec_issue_seq #(.VLEN(128), .LANE_W(32), .NVREG(8), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_insn(in_insn), .in_rs1_val(in_rs1_val), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_vop(out_vop),
      .out_sew(out_sew), .out_vd(out_vd), .out_vs1(out_vs1), .out_vs2(out_vs2),
      .out_beat(out_beat), .out_last(out_last), .out_addr(out_addr),
      .out_scalar(out_scalar), .out_vreg_write(out_vreg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_scalar_wb(out_scalar_wb), .illegal(illegal), .busy(busy)
   );

   typedef struct packed {
      logic [2:0]  vop;
      logic [1:0]  sew;
      logic [2:0]  vd, vs1, vs2;
      logic [1:0]  beat;
      logic        last;
      logic [31:0] addr, scalar;
      logic        vw, mr, mw, swb;
   } beat_t;

   beat_t q[$];
   int    vectors = 0, miscompares = 0;
   logic  exp_illegal = 1'b0, ready_ok = 1'b0, accepted = 1'b0, exp_ready = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected micro-ops for one instruction, straight from the field rules.
   task automatic expand(input logic [31:0] insn, input logic [31:0] rs1);
      logic [4:0] op, vd, vs1, vs2;
      logic [1:0] sew;
      logic [2:0] vop;
      logic       bad;
      int         n;
      beat_t      e;
      if (insn[6:0] != 7'h5B || insn[14:12] != 3'b010) return;
      op = insn[29:25]; sew = insn[31:30];
      vd = insn[11:7]; vs1 = insn[19:15]; vs2 = insn[24:20];
      bad = (sew == 2'b11);
      vop = 3'd0;
      case (op)
         5'd0, 5'd1, 5'd2: begin vop = op[2:0]; bad |= (vd >= NVREG) || (vs1 >= NVREG) || (vs2 >= NVREG); end
         5'd4: begin vop = 3'd3; bad |= (vd >= NVREG); end
         5'd5: begin vop = 3'd4; bad |= (vd >= NVREG); end
         5'd8: begin vop = 3'd5; bad |= (vd >= NVREG); end
         5'd9: begin vop = 3'd6; bad |= (vs2 >= NVREG); end
         default: bad = 1'b1;
      endcase
      if (bad) begin exp_illegal = 1'b1; return; end
      n = (op == 5'd9) ? 1 : NBEATS;
      for (int b = 0; b < n; b++) begin
         e.vop = vop; e.sew = sew; e.vd = vd[2:0]; e.vs1 = vs1[2:0]; e.vs2 = vs2[2:0];
         e.beat = 2'(b); e.last = (b == n - 1);
         e.addr = (op == 5'd4 || op == 5'd5) ? rs1 + 32'(b * 4) : 32'd0;
         e.scalar = rs1;
         e.vw = (op == 5'd0 || op == 5'd1 || op == 5'd2 || op == 5'd4 || op == 5'd8);
         e.mr = (op == 5'd4); e.mw = (op == 5'd5); e.swb = (op == 5'd9);
         q.push_back(e);
      end
   endtask

   task automatic check_outputs();
      beat_t e;
      logic  vld;
      vld = rst_n && (q.size() > 0);
      e = vld ? q[0] : '0;
      exp_ready = rst_n && ready_ok && !flush && ((q.size() == 0) || (out_ready && q[0].last));
      chk("out_valid", out_valid, vld);
      chk("busy", busy, vld);
      chk("in_ready", in_ready, exp_ready);
      chk("illegal", illegal, rst_n && exp_illegal);
      chk("vop", out_vop, e.vop);
      chk("sew", out_sew, e.sew);
      chk("vd", out_vd, e.vd);
      chk("vs1", out_vs1, e.vs1);
      chk("vs2", out_vs2, e.vs2);
      chk("beat", out_beat, e.beat);
      chk("last", out_last, e.last);
      chk("addr", out_addr, e.addr);
      chk("scalar", out_scalar, e.scalar);
      chk("vreg_write", out_vreg_write, e.vw);
      chk("mem_read", out_mem_read, e.mr);
      chk("mem_write", out_mem_write, e.mw);
      chk("scalar_wb", out_scalar_wb, e.swb);
   endtask

   task automatic model_step();
      if (!rst_n) begin
         q.delete(); ready_ok = 1'b0; exp_illegal = 1'b0; accepted = 1'b0;
         return;
      end
      accepted    = in_valid && exp_ready;
      exp_illegal = 1'b0;
      if (flush) q.delete();
      else begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (accepted) begin
            $display("accept insn=%h rs1=%h t=%0t", in_insn, in_rs1_val, $time);
            expand(in_insn, in_rs1_val);
         end
      end
      ready_ok = 1'b1;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic pct(input int p);
      return $urandom_range(0, 99) < p;
   endfunction

   task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input int rdy, input int fl);
      in_valid = 1'b1; in_insn = insn; in_rs1_val = rs1;
      accepted = 1'b0;
      for (int i = 0; i < 200 && !accepted; i++) begin
         out_ready = pct(rdy); flush = pct(fl);
         cycle();
      end
      if (!accepted) begin miscompares++; $error("FAIL accept_timeout insn=%h", insn); end
      in_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic drain(input int rdy, input int fl);
      in_valid = 1'b0;
      for (int i = 0; i < 300 && q.size() > 0; i++) begin
         out_ready = pct(rdy); flush = pct(fl);
         cycle();
      end
      if (q.size() > 0) begin miscompares++; $error("FAIL drain_timeout left=%0d", q.size()); end
      flush = 1'b0; out_ready = 1'b1;
      cycle();
   endtask

   function automatic logic [31:0] rand_insn();
      logic [31:0] r;
      logic [4:0]  op;
      logic [1:0]  sew;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: op = 5'd0;  1: op = 5'd1;  2: op = 5'd2;
         3: op = 5'd4;  4: op = 5'd5;  5: op = 5'd8;
         6: op = 5'd9;  7: op = 5'd3;  8: op = 5'd31;
         default: return {r[31:7], 7'h13};
      endcase
      sew = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      return {sew, op, 5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)), 3'b010,
              5'($urandom_range(0, 8)), 7'h5B};
   endfunction

   initial begin
      cycle(); cycle();
      rst_n = 1'b1;
      cycle();

      issue(32'h8020A1DB, 32'h0, 100, 0);          drain(100, 0);
      issue(32'h8802A0DB, 32'h0000_1000, 100, 0);  drain(100, 0);
      issue(32'h8802A0DB, 32'hFFFF_FFF8, 100, 0);  drain(100, 0);

      issue(32'h8020A1DB, 32'h0, 100, 0);
      out_ready = 1'b1; cycle();
      out_ready = 1'b0; cycle(); cycle(); cycle();
      drain(100, 0);

      issue(32'h8020A1DB, 32'h0, 100, 0);
      issue(32'h8220A1DB, 32'h0, 100, 0);
      drain(100, 0);

      issue(32'h8620A1DB, 32'h0, 100, 0);  drain(100, 0);
      issue(32'hC020A1DB, 32'h0, 100, 0);  drain(100, 0);
      issue(32'h8020A4DB, 32'h0, 100, 0);  drain(100, 0);
      issue(32'h00100093, 32'h0, 100, 0);  drain(100, 0);

      issue(32'h8A20A1DB, 32'h0000_2000, 100, 0);
      out_ready = 1'b1; cycle(); cycle();
      flush = 1'b1; in_valid = 1'b1; in_insn = 32'h8020A1DB; cycle();
      flush = 1'b0; in_valid = 1'b0; cycle();
      drain(100, 0);

      issue(32'h8020A1DB, 32'h0, 100, 0);
      out_ready = 1'b1; cycle();
      rst_n = 1'b0; cycle();
      rst_n = 1'b1; cycle();
      issue(32'h8020A1DB, 32'h0, 100, 0);  drain(100, 0);

      issue(32'h9220A1DB, 32'hDEAD_BEEF, 100, 0);  drain(100, 0);
      issue(32'h9020A1DB, 32'hDEAD_BEEF, 100, 0);  drain(100, 0);

      for (int n = 0; n < 80; n++) begin
         issue(rand_insn(), $urandom, 70, 3);
         if ($urandom_range(0, 3) == 0) drain(60, 2);
      end
      drain(100, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
